// File: rtl/overload_tx_if.sv
// Bit-strobe, bus-level and status bundle between the overload transmitter and its neighbours
// (frame-maker logic, bit-timing unit and CAN transceiver).
interface overload_tx_if;
    logic tx_point;
    logic sample_point;
    logic can_rx;
    logic start_overload;
    logic frame_done;
    logic can_tx;
    logic busy;
    logic end_overload;
    logic bit_error;
    logic superpos_fault;
    logic req_dropped;

    modport master (
        output tx_point, sample_point, can_rx, start_overload, frame_done,
        input  can_tx, busy, end_overload, bit_error, superpos_fault, req_dropped
    );

    modport slave (
        input  tx_point, sample_point, can_rx, start_overload, frame_done,
        output can_tx, busy, end_overload, bit_error, superpos_fault, req_dropped
    );
endinterface

// File: rtl/overload_tx.sv
// CAN overload-frame transmitter: drives flag and delimiter, monitors the bus every sample point.
// Optional per-frame overload limit is enabled with the CAN_OVL_LIMIT_EN macro.
module overload_tx #(
    parameter int FLAG_BITS    = 6,
    parameter int DELIM_BITS   = 8,
    parameter int MAX_SUPERPOS = 7
) (
    input  logic          clock,
    input  logic          reset,
    overload_tx_if.slave  bus
);
    localparam int MAX_A = (FLAG_BITS > DELIM_BITS) ? FLAG_BITS : DELIM_BITS;
    localparam int MAX_B = (MAX_A > MAX_SUPERPOS) ? MAX_A : MAX_SUPERPOS;
    localparam int CNT_W = $clog2(MAX_B) + 1;

    localparam logic [CNT_W-1:0] CNT_ZERO   = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0] CNT_ONE    = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0] FLAG_LAST  = CNT_W'(FLAG_BITS - 1);
    localparam logic [CNT_W-1:0] DELIM_LAST = CNT_W'(DELIM_BITS - 1);
    localparam logic [CNT_W-1:0] SP_LAST    = CNT_W'(MAX_SUPERPOS - 1);

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_PEND     = 3'd1,
        ST_FLAG     = 3'd2,
        ST_SUPERPOS = 3'd3,
        ST_DELIM    = 3'd4
    } state_t;

    state_t           state_r;
    state_t           state_s;
    logic [CNT_W-1:0] bit_cnt_r;
    logic [CNT_W-1:0] bit_cnt_s;
    logic             can_tx_r;
    logic             busy_r;
    logic             end_r;
    logic             end_s;
    logic             err_r;
    logic             err_s;
    logic             flt_r;
    logic             flt_s;
    logic             drop_r;
    logic             drop_s;
    logic             limit_hit_s;

`ifdef CAN_OVL_LIMIT_EN
    logic [1:0] ovl_cnt_r;
    logic       ovl_inc_s;

    // Both the normal delimiter end and the restart happen on the last delimiter sample.
    assign ovl_inc_s   = bus.sample_point && (state_r == ST_DELIM) && (bit_cnt_r == DELIM_LAST);
    assign limit_hit_s = (ovl_cnt_r == 2'd2);

    // Saturating count of overload frames since the last completed data/remote frame.
    always_ff @(posedge clock) begin
        if (reset) begin
            ovl_cnt_r <= 2'd0;
        end else if (bus.frame_done) begin
            ovl_cnt_r <= 2'd0;
        end else if (ovl_inc_s && (ovl_cnt_r != 2'd2)) begin
            ovl_cnt_r <= ovl_cnt_r + 2'd1;
        end else begin
            ovl_cnt_r <= ovl_cnt_r;
        end
    end
`else
    assign limit_hit_s = 1'b0;
`endif

    // Next-state decision; bus samples act before the tx strobe so canTX follows the new state.
    always_comb begin
        state_s   = state_r;
        bit_cnt_s = bit_cnt_r;
        end_s     = 1'b0;
        err_s     = 1'b0;
        flt_s     = 1'b0;
        drop_s    = 1'b0;
        case (state_r)
            ST_IDLE: begin
                // A request coinciding with the endOverload pulse is deliberately dropped.
                if (bus.start_overload && !end_r) begin
                    if (limit_hit_s) begin
                        drop_s = 1'b1;
                    end else begin
                        state_s = ST_PEND;
                    end
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_PEND: begin
                if (bus.tx_point) begin
                    state_s   = ST_FLAG;
                    bit_cnt_s = CNT_ZERO;
                end else begin
                    state_s = ST_PEND;
                end
            end
            ST_FLAG: begin
                if (!bus.sample_point) begin
                    state_s = ST_FLAG;
                end else if (bus.can_rx) begin
                    err_s     = 1'b1;
                    state_s   = ST_IDLE;
                    bit_cnt_s = CNT_ZERO;
                end else if (bit_cnt_r == FLAG_LAST) begin
                    state_s   = ST_SUPERPOS;
                    bit_cnt_s = CNT_ZERO;
                end else begin
                    bit_cnt_s = bit_cnt_r + CNT_ONE;
                end
            end
            ST_SUPERPOS: begin
                if (!bus.sample_point) begin
                    state_s = ST_SUPERPOS;
                end else if (bus.can_rx) begin
                    state_s   = ST_DELIM;
                    bit_cnt_s = CNT_ONE;
                end else if (bit_cnt_r == SP_LAST) begin
                    flt_s     = 1'b1;
                    state_s   = ST_IDLE;
                    bit_cnt_s = CNT_ZERO;
                end else begin
                    bit_cnt_s = bit_cnt_r + CNT_ONE;
                end
            end
            ST_DELIM: begin
                if (!bus.sample_point) begin
                    state_s = ST_DELIM;
                end else if (bit_cnt_r == DELIM_LAST) begin
                    bit_cnt_s = CNT_ZERO;
                    if (bus.can_rx) begin
                        end_s   = 1'b1;
                        state_s = ST_IDLE;
                    end else if (limit_hit_s) begin
                        drop_s  = 1'b1;
                        state_s = ST_IDLE;
                    end else begin
                        state_s = ST_PEND;
                    end
                end else if (bus.can_rx) begin
                    bit_cnt_s = bit_cnt_r + CNT_ONE;
                end else begin
                    err_s     = 1'b1;
                    state_s   = ST_IDLE;
                    bit_cnt_s = CNT_ZERO;
                end
            end
            default: begin
                state_s   = ST_IDLE;
                bit_cnt_s = CNT_ZERO;
            end
        endcase
    end

    // State, counter and all outputs are registered; canTX only changes on a tx strobe.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_r   <= ST_IDLE;
            bit_cnt_r <= CNT_ZERO;
            can_tx_r  <= 1'b1;
            busy_r    <= 1'b0;
            end_r     <= 1'b0;
            err_r     <= 1'b0;
            flt_r     <= 1'b0;
            drop_r    <= 1'b0;
        end else begin
            state_r   <= state_s;
            bit_cnt_r <= bit_cnt_s;
            busy_r    <= (state_s != ST_IDLE);
            end_r     <= end_s;
            err_r     <= err_s;
            flt_r     <= flt_s;
            drop_r    <= drop_s;
            if (bus.tx_point) begin
                can_tx_r <= (state_s == ST_FLAG) ? 1'b0 : 1'b1;
            end else begin
                can_tx_r <= can_tx_r;
            end
        end
    end

    assign bus.can_tx         = can_tx_r;
    assign bus.busy           = busy_r;
    assign bus.end_overload   = end_r;
    assign bus.bit_error      = err_r;
    assign bus.superpos_fault = flt_r;
    assign bus.req_dropped    = drop_r;
endmodule

// File: tb/tb_overload_tx.sv
// Self-checking bench for overload_tx: randomized bit-level scenarios checked against
// event positions computed arithmetically from the overload-frame rules.
module tb_overload_tx;
    localparam int FLAG_N  = 6;
    localparam int DELIM_N = 8;
    localparam int MAX_SP  = 7;

    logic clock = 1'b0;
    logic reset;
    overload_tx_if bus();

    overload_tx dut (.clock(clock), .reset(reset), .bus(bus));

    always #5 clock = ~clock;

    int checks = 0;
    int errors = 0;
    int bit_idx = 0;
    int n_dom_tx = 0;
    int n_end = 0, n_err = 0, n_flt = 0, n_drop = 0;
    int end_bit = 0, err_bit = 0, flt_bit = 0;
    logic dom_at [0:63];
    logic rec_at [0:63];
    logic req_on_end;

    // Event monitor: counts every pulse-cycle and remembers the bit it fell in.
    always @(negedge clock) begin
        if (bus.end_overload === 1'b1) begin n_end++; end_bit = bit_idx; end
        if (bus.bit_error === 1'b1) begin n_err++; err_bit = bit_idx; end
        if (bus.superpos_fault === 1'b1) begin n_flt++; flt_bit = bit_idx; end
        if (bus.req_dropped === 1'b1) n_drop++;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic clear_plan();
        for (int i = 0; i < 64; i++) begin
            dom_at[i] = 1'b0;
            rec_at[i] = 1'b0;
        end
        bit_idx = 0;
        n_dom_tx = 0;
        req_on_end = 1'b0;
    endtask

    task automatic frame_end();
        bus.frame_done = 1'b1;
        @(negedge clock);
        bus.frame_done = 1'b0;
    endtask

    task automatic request();
        bus.start_overload = 1'b1;
        @(negedge clock);
        bus.start_overload = 1'b0;
    endtask

    // One CAN bit: tx strobe, random gap, sample strobe; the bus is the wired-AND of us and others.
    task automatic run_bit();
        logic tx_lvl;
        bit_idx++;
        bus.tx_point = 1'b1;
        @(negedge clock);
        bus.tx_point = 1'b0;
        tx_lvl = bus.can_tx;
        if (tx_lvl === 1'b0) n_dom_tx++;
        repeat ($urandom_range(0, 2)) @(negedge clock);
        bus.can_rx = rec_at[bit_idx] ? 1'b1 : (tx_lvl & ~dom_at[bit_idx]);
        bus.sample_point = 1'b1;
        @(negedge clock);
        bus.sample_point = 1'b0;
        if (req_on_end && (bus.end_overload === 1'b1)) begin
            bus.start_overload = 1'b1;
            @(negedge clock);
            bus.start_overload = 1'b0;
        end else begin
            @(negedge clock);
        end
        bus.can_rx = 1'b1;
    endtask

    // Flag followed by k dominant bits from other nodes, then a recessive bus.
    task automatic scen_a(input int k, input bit fresh, input bit roe);
        int b_end, b_err, b_flt, nb;
        if (fresh) frame_end();
        clear_plan();
        req_on_end = roe;
        for (int i = FLAG_N + 1; i <= FLAG_N + k; i++) dom_at[i] = 1'b1;
        b_end = n_end; b_err = n_err; b_flt = n_flt;
        request();
        check("pend_busy", bus.busy, 1);
        nb = (k >= MAX_SP) ? FLAG_N + MAX_SP + 2 : FLAG_N + k + DELIM_N + 2;
        repeat (nb) run_bit();
        if (k >= MAX_SP) begin
            check("sp_fault_cnt", n_flt - b_flt, 1);
            check("sp_fault_bit", flt_bit, FLAG_N + MAX_SP);
            check("sp_no_end", n_end - b_end, 0);
        end else begin
            check("end_cnt", n_end - b_end, 1);
            check("end_bit", end_bit, FLAG_N + k + DELIM_N);
            check("sp_no_fault", n_flt - b_flt, 0);
        end
        check("a_no_err", n_err - b_err, 0);
        check("a_flag_len", n_dom_tx, FLAG_N);
        check("a_idle", bus.busy, 0);
        check("a_tx_rec", bus.can_tx, 1);
    endtask

    // Recessive read on flag bit p.
    task automatic scen_b(input int p);
        int b_end, b_err;
        frame_end();
        clear_plan();
        rec_at[p] = 1'b1;
        b_end = n_end; b_err = n_err;
        request();
        repeat (p + 2) run_bit();
        check("b_err_cnt", n_err - b_err, 1);
        check("b_err_bit", err_bit, p);
        check("b_dom_bits", n_dom_tx, p);
        check("b_no_end", n_end - b_end, 0);
        check("b_idle", bus.busy, 0);
    endtask

    // Dominant read on delimiter bit d (d == DELIM_N restarts a whole new overload frame).
    task automatic scen_c(input int d);
        int b_end, b_err;
        frame_end();
        clear_plan();
        dom_at[FLAG_N + d] = 1'b1;
        b_end = n_end; b_err = n_err;
        request();
        if (d < DELIM_N) begin
            repeat (FLAG_N + d + 2) run_bit();
            check("c_err_cnt", n_err - b_err, 1);
            check("c_err_bit", err_bit, FLAG_N + d);
            check("c_dom_bits", n_dom_tx, FLAG_N);
            check("c_no_end", n_end - b_end, 0);
        end else begin
            repeat (2 * (FLAG_N + DELIM_N) + 2) run_bit();
            check("c_restart_end", n_end - b_end, 1);
            check("c_restart_bit", end_bit, 2 * (FLAG_N + DELIM_N));
            check("c_restart_dom", n_dom_tx, 2 * FLAG_N);
            check("c_restart_no_err", n_err - b_err, 0);
        end
        check("c_idle", bus.busy, 0);
    endtask

    initial begin
        int b_end, b_err, b_drop;
        reset = 1'b1;
        bus.tx_point = 1'b0;
        bus.sample_point = 1'b0;
        bus.can_rx = 1'b1;
        bus.start_overload = 1'b0;
        bus.frame_done = 1'b0;
        clear_plan();
        repeat (3) @(negedge clock);
        check("rst_can_tx", bus.can_tx, 1);
        check("rst_busy", bus.busy, 0);
        check("rst_pulses", {bus.end_overload, bus.bit_error, bus.superpos_fault, bus.req_dropped}, 0);
        reset = 1'b0;
        @(negedge clock);

        scen_a(0, 1'b1, 1'b1);
        scen_a(3, 1'b1, 1'b0);
        scen_a(6, 1'b1, 1'b0);
        scen_a(7, 1'b1, 1'b0);
        for (int i = 0; i < 4; i++) scen_a(int'($urandom_range(0, 9)), 1'b1, 1'b0);

        scen_b(3);
        scen_b(1);
        scen_b(int'($urandom_range(1, 6)));

        scen_c(4);
        scen_c(DELIM_N);
        scen_c(int'($urandom_range(1, 7)));

        // Simultaneous tx and sample strobes: the sample decides the state canTX follows.
        frame_end();
        clear_plan();
        b_err = n_err;
        request();
        bus.tx_point = 1'b1;
        @(negedge clock);
        bus.tx_point = 1'b0;
        check("sim_flag_start", bus.can_tx, 0);
        bus.can_rx = 1'b0;
        bus.tx_point = 1'b1;
        bus.sample_point = 1'b1;
        @(negedge clock);
        check("sim_flag_hold", bus.can_tx, 0);
        bus.can_rx = 1'b1;
        @(negedge clock);
        bus.tx_point = 1'b0;
        bus.sample_point = 1'b0;
        check("sim_err_tx", bus.can_tx, 1);
        check("sim_err_pulse", bus.bit_error, 1);
        @(negedge clock);
        check("sim_err_cnt", n_err - b_err, 1);
        check("sim_idle", bus.busy, 0);

        // Reset in the middle of the flag.
        frame_end();
        clear_plan();
        b_end = n_end; b_err = n_err;
        request();
        repeat (3) run_bit();
        check("mid_flag_tx", bus.can_tx, 0);
        reset = 1'b1;
        @(negedge clock);
        check("mid_rst_tx", bus.can_tx, 1);
        check("mid_rst_busy", bus.busy, 0);
        reset = 1'b0;
        repeat (2) @(negedge clock);
        check("mid_rst_nopulse", (n_end - b_end) + (n_err - b_err), 0);

        // Overload limit: two frames then a third request with no frame completed between.
        scen_a(0, 1'b1, 1'b0);
        scen_a(0, 1'b0, 1'b0);
        b_drop = n_drop;
        b_end = n_end;
        request();
`ifdef CAN_OVL_LIMIT_EN
        check("lim_drop_pulse", bus.req_dropped, 1);
        check("lim_drop_busy", bus.busy, 0);
        @(negedge clock);
        check("lim_drop_cnt", n_drop - b_drop, 1);
        scen_a(0, 1'b1, 1'b0);
`else
        check("nolim_no_drop", bus.req_dropped, 0);
        check("nolim_busy", bus.busy, 1);
        clear_plan();
        repeat (FLAG_N + DELIM_N + 2) run_bit();
        check("nolim_end", n_end - b_end, 1);
        check("nolim_drop_cnt", n_drop - b_drop, 0);
`endif
        check("final_idle", bus.busy, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
